// File: rtl/rnd_sample_ctrl_pkg.sv
// Shared types and constants for the random-sample controller.
// Holds the FSM state encoding, the debias pair codes and the FIFO default.
package rnd_sample_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD,
    ST_EXTRACT
  } state_t;

  // Von Neumann debias codes: {odd bit, even bit} of one sample pair
  localparam logic [1:0] PAIR_ONE  = 2'b10;
  localparam logic [1:0] PAIR_ZERO = 2'b01;

  localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/rnd_sample_ctrl_byte_fifo.sv
// First-word fall-through byte FIFO with synchronous reset.
// Head reads as zero while empty; a push while full only lands alongside a pop.
module byte_fifo
  import rnd_sample_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop_en;
  logic          push_en;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rnd_sample_ctrl.sv
// Sampling loop around an external free-running generator: run, freeze, capture
// 16 raw bits, debias them pairwise into bytes, and queue the bytes in a FIFO.
module rnd_sample_ctrl
  import rnd_sample_ctrl_pkg::*;
#(
  parameter int SETTLE_W   = 8,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic                rnd_freeze,
  input  logic [15:0]         rnd_in,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic [7:0]          drop_cnt
);

  state_t              state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [SETTLE_W-1:0] settle_load;
  logic                hold_cnt;
  logic [2:0]          pair_idx;
  logic [15:0]         sample;
  logic [1:0]          pair;
  logic                accept;
  logic                acc_bit;
  logic [7:0]          acc;
  logic [7:0]          acc_nx;
  logic [3:0]          bit_cnt;
  logic [2:0]          bit_idx;
  logic                byte_done;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop_en;
  logic                fifo_drop;

  assign settle_load = (settle_cycles == '0) ? SETTLE_W'(1) : settle_cycles;

  // Sequencer: state and its registered outputs move together
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rnd_freeze <= 1'b1;
      busy       <= 1'b0;
      settle_cnt <= '0;
      hold_cnt   <= 1'b0;
      pair_idx   <= '0;
      sample     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state      <= ST_RUN;
            settle_cnt <= settle_load;
            rnd_freeze <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state      <= ST_IDLE;
            rnd_freeze <= 1'b1;
            busy       <= 1'b0;
          end else if (settle_cnt == SETTLE_W'(1)) begin
            state      <= ST_HOLD;
            hold_cnt   <= 1'b0;
            rnd_freeze <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
          end
        end
        ST_HOLD: begin
          // Generator is frozen here, so rnd_in is stable when captured
          if (hold_cnt) begin
            state    <= ST_EXTRACT;
            sample   <= rnd_in;
            pair_idx <= '0;
          end else begin
            hold_cnt <= 1'b1;
          end
        end
        ST_EXTRACT: begin
          if (pair_idx == 3'd7) begin
            if (enable) begin
              state      <= ST_RUN;
              settle_cnt <= settle_load;
              rnd_freeze <= 1'b0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            pair_idx <= pair_idx + 3'd1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          rnd_freeze <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  assign pair      = sample[{pair_idx, 1'b0} +: 2];
  assign accept    = (state == ST_EXTRACT) && ((pair == PAIR_ONE) || (pair == PAIR_ZERO));
  assign acc_bit   = (pair == PAIR_ONE);
  assign byte_done = bit_cnt[3];
  // A bit accepted while the full byte is leaving starts the next byte at bit 0
  assign bit_idx   = byte_done ? 3'd0 : bit_cnt[2:0];

  always_comb begin
    acc_nx          = byte_done ? 8'h00 : acc;
    acc_nx[bit_idx] = acc_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      acc     <= acc_nx;
      bit_cnt <= {1'b0, bit_idx} + 4'd1;
    end else if (byte_done) begin
      acc     <= '0;
      bit_cnt <= '0;
    end
  end

  assign pop_en    = out_ready && out_valid;
  assign fifo_drop = byte_done && fifo_full && !pop_en;
  assign out_valid = !fifo_empty;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (byte_done),
    .push_data (acc),
    .pop       (out_ready),
    .head      (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= '0;
    else if (fifo_drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
  end

endmodule

// File: tb/tb_rnd_sample_ctrl.sv
// Bench for rnd_sample_ctrl: a sample-period model predicts every output each
// cycle; directed scenarios add literal expectations, then random traffic runs.
module tb_rnd_sample_ctrl;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [7:0]  settle_cycles;
  logic        rnd_freeze;
  logic [15:0] rnd_in;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [7:0]  drop_cnt;

  rnd_sample_ctrl #(.SETTLE_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .settle_cycles (settle_cycles),
    .rnd_freeze    (rnd_freeze),
    .rnd_in        (rnd_in),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .drop_cnt      (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Model: a period is S run cycles, 2 hold cycles, 8 extract cycles.
  // m_pos is the position inside the period of the cycle now under way.
  bit          m_ok = 0;
  bit          m_run;
  int          m_pos, m_S, m_pb, m_pc, m_drop, m_due_b, m_k, m_p;
  bit          m_due, m_pop;
  logic [15:0] m_smp;
  int          m_q[$];
  int          e_frz, e_busy, e_valid, e_data, e_drop;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_q.delete();
      m_run = 0; m_pos = 0; m_S = 1; m_pb = 0; m_pc = 0;
      m_due = 0; m_drop = 0; m_smp = '0; m_ok = 1;
    end else begin
      m_pop = out_ready && (m_q.size() > 0);
      if (m_pop) void'(m_q.pop_front());
      if (m_due) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_due_b);
        else if (m_drop < 255) m_drop++;
        m_due = 0;
      end
      if (!m_run) begin
        if (enable) begin
          m_run = 1; m_pos = 0; m_S = (settle_cycles == 0) ? 1 : int'(settle_cycles);
        end
      end else if (m_pos < m_S) begin
        if (!enable) m_run = 0;
        else m_pos++;
      end else if (m_pos == m_S + 1) begin
        m_smp = rnd_in;
        m_pos++;
      end else if (m_pos >= m_S + 2) begin
        m_k = m_pos - m_S - 2;
        m_p = (int'(m_smp) >> (2 * m_k)) & 3;
        if (m_p == 1 || m_p == 2) begin
          if (m_p == 2) m_pb = m_pb + (1 << m_pc);
          m_pc++;
          if (m_pc == 8) begin
            m_due = 1; m_due_b = m_pb; m_pb = 0; m_pc = 0;
          end
        end
        if (m_k == 7) begin
          if (enable) begin
            m_pos = 0; m_S = (settle_cycles == 0) ? 1 : int'(settle_cycles);
          end else m_run = 0;
        end else m_pos++;
      end else begin
        m_pos++;
      end
    end
    e_frz   = (m_run && m_pos < m_S) ? 0 : 1;
    e_busy  = m_run ? 1 : 0;
    e_valid = (m_q.size() > 0) ? 1 : 0;
    e_data  = (m_q.size() > 0) ? m_q[0] : 0;
    e_drop  = m_drop;
  end

  int log_b[$];
  int log_c[$];

  always @(negedge clk) begin
    if (m_ok) begin
      chk("freeze", rnd_freeze, e_frz);
      chk("busy", busy, e_busy);
      chk("out_valid", out_valid, e_valid);
      chk("out_data", out_data, e_data);
      chk("drop_cnt", drop_cnt, e_drop);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        log_b.push_back(int'(out_data));
        log_c.push_back(cyc);
      end
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    cyc_n(2);
    log_b.delete();
    log_c.delete();
    rst = 1'b0;
  endtask

  task automatic wait_frz(input logic v, input int lim, input string nm);
    int n = 0;
    while (rnd_freeze !== v && n < lim) begin @(negedge clk); n++; end
    chk(nm, rnd_freeze, v);
  endtask

  task automatic finish_run(input string nm);
    int n = 0;
    enable = 1'b0;
    while (busy !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    chk(nm, busy, 0);
    cyc_n(3);
  endtask

  task automatic run_len(input logic v, output int n);
    n = 0;
    while (rnd_freeze === v && n < 100) begin @(negedge clk); n++; end
  endtask

  int n, vcnt;
  logic [15:0] pats [5] = '{16'hAAAA, 16'h5555, 16'h0009, 16'h0000, 16'hFFFF};

  initial begin
    rst = 1'b1; enable = 1'b0; settle_cycles = 8'd3; rnd_in = '0; out_ready = 1'b1;
    cyc_n(3);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_freeze", rnd_freeze, 1);
    chk("rst_drop", drop_cnt, 0);

    // Scenario 1: 3 run + 10 frozen cycles, one 8'hFF every 13 cycles
    rst = 1'b0; rnd_in = 16'hAAAA; settle_cycles = 8'd3; enable = 1'b1;
    wait_frz(1'b0, 5, "s1_start");
    run_len(1'b0, n); chk("s1_run_len", n, 3);
    run_len(1'b1, n); chk("s1_frozen_len", n, 10);
    cyc_n(60);
    finish_run("s1_idle");
    chk("s1_nbytes_ge4", (log_b.size() >= 4) ? 1 : 0, 1);
    foreach (log_b[i]) chk("s1_byte", log_b[i], 'hFF);
    chk("s1_period", (log_c.size() >= 2) ? log_c[1] - log_c[0] : 0, 13);

    // Scenario 2: 5555 yields zero bytes, 0000 / FFFF yield nothing
    do_reset();
    rnd_in = 16'h5555; enable = 1'b1;
    cyc_n(45);
    finish_run("s2_idle_a");
    chk("s2_nbytes_ge3", (log_b.size() >= 3) ? 1 : 0, 1);
    foreach (log_b[i]) chk("s2_byte", log_b[i], 'h00);
    do_reset();
    vcnt = 0;
    rnd_in = 16'h0000; enable = 1'b1;
    for (int i = 0; i < 130; i++) begin @(negedge clk); if (out_valid) vcnt++; end
    rnd_in = 16'hFFFF;
    for (int i = 0; i < 130; i++) begin @(negedge clk); if (out_valid) vcnt++; end
    finish_run("s2_idle_b");
    chk("s2_no_valid", vcnt, 0);

    // Scenario 3: two bits per sample, one 8'hAA after four samples
    do_reset();
    rnd_in = 16'h0009; enable = 1'b1;
    cyc_n(70);
    finish_run("s3_idle");
    chk("s3_nbytes", log_b.size(), 1);
    chk("s3_byte", (log_b.size() > 0) ? log_b[0] : -1, 'hAA);

    // Scenario 4: stalled consumer fills the FIFO and drops three bytes
    do_reset();
    out_ready = 1'b0; rnd_in = 16'hAAAA; enable = 1'b1;
    n = 0;
    while (drop_cnt !== 8'd3 && n < 150) begin @(negedge clk); n++; end
    finish_run("s4_idle");
    chk("s4_drop", drop_cnt, 3);
    chk("s4_valid", out_valid, 1);
    chk("s4_no_pops", log_b.size(), 0);
    out_ready = 1'b1;
    cyc_n(8);
    chk("s4_npops", log_b.size(), 4);
    foreach (log_b[i]) chk("s4_byte", log_b[i], 'hFF);
    chk("s4_empty", out_valid, 0);
    chk("s4_drop_kept", drop_cnt, 3);

    // Drop counter saturation, settle of 0 runs as 1 (11-cycle period)
    do_reset();
    out_ready = 1'b0; settle_cycles = 8'd0; rnd_in = 16'hAAAA; enable = 1'b1;
    cyc_n(265 * 11);
    finish_run("sat_idle");
    chk("sat_drop", drop_cnt, 255);
    out_ready = 1'b1;

    // Scenario 5a: enable dropped in RUN
    do_reset();
    settle_cycles = 8'd10; rnd_in = 16'hAAAA; enable = 1'b1;
    cyc_n(4);
    enable = 1'b0;
    cyc_n(1);
    chk("s5_run_busy", busy, 0);
    chk("s5_run_freeze", rnd_freeze, 1);
    cyc_n(20);
    chk("s5_run_nopush", log_b.size(), 0);
    // Scenario 5b: enable dropped in EXTRACT, sample still completes
    enable = 1'b1;
    wait_frz(1'b0, 5, "s5_x_run");
    wait_frz(1'b1, 20, "s5_x_hold");
    cyc_n(4);
    enable = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 30) begin @(negedge clk); n++; end
    chk("s5_x_tail", n, 6);
    cyc_n(3);
    chk("s5_x_nbytes", log_b.size(), 1);
    chk("s5_x_byte", (log_b.size() > 0) ? log_b[0] : -1, 'hFF);

    // Scenario 6: reset during EXTRACT with five zero bits collected
    do_reset();
    settle_cycles = 8'd3; rnd_in = 16'h5555; enable = 1'b1;
    wait_frz(1'b0, 5, "s6_run");
    wait_frz(1'b1, 10, "s6_hold");
    cyc_n(7);
    rst = 1'b1;
    cyc_n(1);
    chk("s6_busy", busy, 0);
    chk("s6_freeze", rnd_freeze, 1);
    chk("s6_valid", out_valid, 0);
    chk("s6_data", out_data, 0);
    chk("s6_drop", drop_cnt, 0);
    log_b.delete(); log_c.delete();
    rst = 1'b0; rnd_in = 16'hAAAA;
    n = 0;
    while (log_b.size() == 0 && n < 40) begin @(negedge clk); n++; end
    finish_run("s6_idle");
    chk("s6_first_byte", (log_b.size() > 0) ? log_b[0] : -1, 'hFF);

    // Random traffic, model-checked every cycle
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      out_ready = ($urandom_range(0, 2) != 0);
      settle_cycles = 8'($urandom_range(0, 6));
      n = $urandom_range(0, 6);
      rnd_in = (n < 5) ? pats[n] : 16'($urandom);
    end
    rst = 1'b0;
    finish_run("rnd_idle");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rnd_sample_ctrl.md
RND_SAMPLE_CTRL -- requirements
Module: rnd_sample_ctrl

Interface
REQ-001 Parameter SETTLE_W, default 8: width of settle_cycles.
REQ-002 Parameter FIFO_DEPTH, default 4: output byte FIFO entries, power of two, at least 2.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  level; 1 = run sampling loop.
REQ-006 settle_cycles  input  SETTLE_W  run-time length per sample, in cycles.
REQ-007 rnd_freeze  output  1  drives generator G; 1 = frozen, 0 = running.
REQ-008 rnd_in  input  16  raw generator bits R, asynchronous to clk.
REQ-009 out_data  output  8  FIFO head byte.
REQ-010 out_valid  output  1  FIFO non-empty.
REQ-011 out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both 1.
REQ-012 busy  output  1  FSM not in IDLE.
REQ-013 drop_cnt  output  8  saturating count of bytes lost to a full FIFO.

Function
REQ-014 FSM states are IDLE, RUN, HOLD and EXTRACT.
REQ-015 IDLE: rnd_freeze=1; go to RUN when enable=1.
REQ-016 On entry to RUN, a settle counter loads settle_cycles, with 0 treated as 1.
REQ-017 RUN: rnd_freeze=0; stay for exactly the loaded count of cycles, then go to HOLD.
REQ-018 RUN with enable=0 goes to IDLE on the next edge and drops the sample.
REQ-019 HOLD: rnd_freeze=1 for exactly 2 cycles for settle and metastability margin.
REQ-020 On leaving HOLD, rnd_in is captured into a 16-bit sample register; go to EXTRACT.
REQ-021 EXTRACT lasts exactly 8 cycles and processes pair k (k=0..7), p={sample[2k+1],sample[2k]}, in cycle k.
REQ-022 Debias rule: p=2'b10 accepts bit 1, p=2'b01 accepts bit 0, and 2'b00 or 2'b11 is discarded.
REQ-023 Each accepted bit is written to acc[bit_cnt], then bit_cnt increments; the first accepted bit lands in the LSB.
REQ-024 When bit_cnt reaches 8, the completed byte is pushed the next cycle and bit_cnt wraps to 0.
REQ-025 Partial bytes carry across samples.
REQ-026 After EXTRACT: go to RUN if enable=1, else IDLE; enable is ignored during HOLD and EXTRACT.
REQ-027 A push with FIFO full and no simultaneous pop is dropped and drop_cnt increments, saturating at 255.
REQ-028 Simultaneous push and pop when full are both accepted and drop_cnt is unchanged.
REQ-029 Pop when empty has no effect; out_data is 0 when empty.
REQ-030 The FIFO is first-word fall-through.
REQ-031 out_valid rises the cycle after a push into an empty FIFO.
REQ-032 Nominal sample period is settle+10 cycles (settle in RUN, 2 in HOLD, 8 in EXTRACT).

Reset
REQ-033 rst=1 at a clock edge forces IDLE, rnd_freeze=1, and clears the FIFO, acc, bit_cnt, sample register and drop_cnt.
REQ-034 After reset: out_valid=0, out_data=0, busy=0.
REQ-035 Reset mid-operation abandons the current sample and partial byte with no push.
REQ-036 rst has priority over every other input.

Structure
REQ-037 A shared package holds the FSM state enum, the pair decode constants (2'b10, 2'b01) and the default FIFO_DEPTH.
REQ-038 The FIFO is one sub-module, byte_fifo (parameterised depth, full/empty flags, FWFT); FSM and packing stay in the top.
REQ-039 The block instantiates no generator; rnd_freeze and rnd_in connect to the existing 16-bit generator externally.

Verification
REQ-040 Scenario 1: settle=3, rnd_in=16'hAAAA, out_ready=1 -> rnd_freeze low 3 cycles, high 2, then 8 EXTRACT cycles; out_data=8'hFF, one byte per 13-cycle period.
REQ-041 Scenario 2: rnd_in=16'h5555 -> stream of 8'h00; rnd_in=16'h0000 or 16'hFFFF -> no out_valid over 10 periods.
REQ-042 Scenario 3: rnd_in=16'h0009 (2 bits/sample) -> after 4 samples, one byte 8'hAA.
REQ-043 Scenario 4: out_ready=0, 16'hAAAA for FIFO_DEPTH+3 samples -> FIFO holds 4 bytes, drop_cnt=3; raise out_ready -> exactly 4 pops of 8'hFF.
REQ-044 Scenario 5: enable dropped in RUN -> IDLE next cycle with rnd_freeze=1 and no push; dropped during EXTRACT -> sample completes first, then IDLE.
REQ-045 Scenario 6: rst asserted during EXTRACT with bit_cnt=5 -> all outputs at reset values next cycle; restart with 16'hAAAA gives first byte 8'hFF (no stale bits).
